if_fetch_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register; drives the decode stage whose control decoder consumes id_opcode.

---
 rtl/rv_pkg.sv | 22 ++
 rtl/fetch_skid_buf.sv | 53 +++++
 rtl/if_fetch_stage.sv | 143 ++++++++++++++
 tb/tb_if_fetch_stage.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32 front-end definitions: datapath width, reset constants,
// base opcodes and the fetch-stage state encoding.
package rv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STYPE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} holding buffer for a fetch response that arrives
// while decode is stalled. Flush beats load, load beats drain.
module fetch_skid_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            drain,
    input  logic            flush,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_instr,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = load_pc;
            instr_d = load_instr;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign instr = instr_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch with one outstanding memory request, a skid entry for
// responses that land during a decode stall, and the IF/ID register.
module if_fetch_stage
    import rv_pkg::*;
#(
    parameter int              XLEN      = rv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = rv_pkg::RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = rv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            id_stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr,
    output logic [6:0]      id_opcode
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            id_valid_q, id_valid_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic [XLEN-1:0] id_instr_q, id_instr_d;

    logic            skid_valid;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] skid_instr;
    logic            skid_load;
    logic            skid_drain;

    logic id_free;
    logic rsp_live;
    logic rsp_to_id;
    logic issue;

    // A live response is one for the request in flight that a redirect is not killing.
    assign id_free    = !id_valid_q || !id_stall;
    assign rsp_live   = (state_q == S_WAIT) && imem_rvalid && !redirect_valid;
    assign rsp_to_id  = rsp_live && id_free && !skid_valid;
    assign issue      = !rst && !skid_valid && !redirect_valid &&
                        ((state_q == S_REQ) || rsp_to_id);
    assign skid_load  = rsp_live && !rsp_to_id;
    assign skid_drain = id_free && skid_valid && !redirect_valid;

    assign imem_req  = issue;
    assign imem_addr = pc_q;

    fetch_skid_buf #(
        .XLEN(XLEN)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .drain     (skid_drain),
        .flush     (redirect_valid),
        .load_pc   (fetch_pc_q),
        .load_instr(imem_rdata),
        .valid     (skid_valid),
        .pc        (skid_pc),
        .instr     (skid_instr)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc & ~(XLEN'(3));
            // A response arriving with the redirect retires the in-flight request.
            case (state_q)
                S_WAIT:  state_d = imem_rvalid ? S_REQ : S_DROP;
                S_DROP:  state_d = imem_rvalid ? S_REQ : S_DROP;
                default: state_d = S_REQ;
            endcase
        end else begin
            if ((state_q == S_DROP) && imem_rvalid) begin
                state_d = S_REQ;
            end
            if (skid_load) begin
                state_d = S_REQ;
            end
            if (issue) begin
                fetch_pc_d = pc_q;
                pc_d       = pc_q + XLEN'(4);
                state_d    = S_WAIT;
            end
        end
    end

    always_comb begin
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        if (redirect_valid) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
        end else if (id_free) begin
            if (skid_valid) begin
                id_valid_d = 1'b1;
                id_pc_d    = skid_pc;
                id_instr_d = skid_instr;
            end else if (rsp_to_id) begin
                id_valid_d = 1'b1;
                id_pc_d    = fetch_pc_q;
                id_instr_d = imem_rdata;
            end else begin
                id_valid_d = 1'b0;
                id_instr_d = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            fetch_pc_q <= '0;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_instr_q <= NOP_INSTR;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
        end
    end

    assign id_valid  = id_valid_q;
    assign id_pc     = id_pc_q;
    assign id_instr  = id_instr_q;
    assign id_opcode = id_instr_q[6:0];

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus a randomized
// run against a memory model and an in-order fetch/retire scoreboard.
module tb_if_fetch_stage;

    localparam logic [31:0] TB_NOP      = 32'h0000_0013;
    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        id_stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [6:0]  id_opcode;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .id_stall      (id_stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_instr      (id_instr),
        .id_opcode     (id_opcode)
    );

    int total_checks = 0;
    int bad_checks   = 0;

    // Reference state: fetched-but-not-retired addresses, expected next fetch
    // address and a single-outstanding memory with programmable latency.
    logic [31:0] sb_q[$];
    logic [31:0] exp_addr = TB_RESET_PC;
    bit          mem_busy = 1'b0;
    int          mem_wait = 0;
    logic [31:0] mem_addr = '0;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          after_reset = 1'b0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_pc = '0;
    logic [31:0] prev_instr = '0;
    int          retired = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total_checks++;
        if (observed !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        logic [31:0] h;
        logic [6:0]  op;
        h = (addr * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
        case (addr[4:2])
            3'd0:    op = 7'b0000011;
            3'd1:    op = 7'b0010011;
            3'd2:    op = 7'b0110011;
            3'd3:    op = 7'b0100011;
            3'd4:    op = 7'b1100011;
            3'd5:    op = 7'b1101111;
            default: op = h[6:0];
        endcase
        return {h[31:7], op};
    endfunction

    // One clock cycle: drive after the edge, check at the falling edge, then
    // advance the reference to what the next rising edge must do.
    task automatic applyStimulus(input bit s_rst, input bit s_stall, input bit s_redir,
                                 input logic [31:0] s_rpc, input bit s_stray);
        bit rsp_now;
        @(posedge clk);
        #1;
        rst            = s_rst;
        id_stall       = s_stall;
        redirect_valid = s_redir;
        redirect_pc    = s_rpc;
        rsp_now        = 1'b0;
        if (mem_busy) begin
            mem_wait--;
            if (mem_wait == 0) rsp_now = 1'b1;
        end
        if (rsp_now) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memWord(mem_addr);
        end else if (s_stray) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        @(negedge clk);
        if (s_rst) begin
            checkOutput("req_in_reset", imem_req, 0);
            mem_busy    = 1'b0;
            sb_q.delete();
            exp_addr    = TB_RESET_PC;
            prev_hold   = 1'b0;
            after_reset = 1'b1;
        end else begin
            if (after_reset) begin
                checkOutput("rst_id_valid", id_valid, 0);
                checkOutput("rst_id_pc", id_pc, 0);
                checkOutput("rst_id_instr", id_instr, TB_NOP);
                after_reset = 1'b0;
            end
            checkOutput("opcode", id_opcode, id_instr[6:0]);
            if (prev_hold) begin
                checkOutput("hold_valid", id_valid, 1);
                checkOutput("hold_pc", id_pc, prev_pc);
                checkOutput("hold_instr", id_instr, prev_instr);
            end
            if (!id_valid) begin
                checkOutput("idle_instr", id_instr, TB_NOP);
            end else begin
                checkOutput("id_expected", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) checkOutput("id_pc_order", id_pc, sb_q[0]);
                checkOutput("id_instr_data", id_instr, memWord(id_pc));
            end
            checkOutput("req_during_redirect", imem_req && s_redir, 0);
            checkOutput("req_while_busy", imem_req && mem_busy && !rsp_now, 0);
            if (imem_req) checkOutput("req_addr", imem_addr, exp_addr);

            if (rsp_now) mem_busy = 1'b0;
            prev_hold  = id_valid && s_stall && !s_redir;
            prev_pc    = id_pc;
            prev_instr = id_instr;
            if (s_redir) begin
                sb_q.delete();
                exp_addr = s_rpc & ~32'd3;
            end else begin
                if (id_valid && !s_stall && sb_q.size() > 0) begin
                    void'(sb_q.pop_front());
                    retired++;
                end
                if (imem_req) begin
                    sb_q.push_back(imem_addr);
                    exp_addr = imem_addr + 32'd4;
                end
            end
            if (imem_req) begin
                mem_busy = 1'b1;
                mem_addr = imem_addr;
                mem_wait = $urandom_range(lat_max, lat_min);
            end
        end
    endtask

    task automatic resetDut();
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 0);
    endtask

    initial begin
        int r0;
        bit do_rst, do_stall, do_redir;
        logic [31:0] tgt;

        $display("[TB] back-to-back fetch, latency 1");
        lat_min = 1; lat_max = 1;
        resetDut();
        for (int i = 0; i < 6; i++) begin
            idleCycle();
            checkOutput("t1_req", imem_req, 1);
            checkOutput("t1_addr", imem_addr, 32'(4 * i));
            checkOutput("t1_id_valid", id_valid, (i >= 2) ? 1 : 0);
            if (i >= 2) checkOutput("t1_id_pc", id_pc, 32'(4 * (i - 2)));
        end

        $display("[TB] stall while response returns");
        resetDut();
        idleCycle();
        idleCycle();
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("t2_c2_req", imem_req, 0);
        checkOutput("t2_c2_pc", id_pc, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("t2_c3_req", imem_req, 0);
        checkOutput("t2_c3_pc", id_pc, 0);
        idleCycle();
        checkOutput("t2_c4_req", imem_req, 0);
        idleCycle();
        checkOutput("t2_c5_pc", id_pc, 32'h4);
        checkOutput("t2_c5_req", imem_req, 1);
        checkOutput("t2_c5_addr", imem_addr, 32'h8);

        $display("[TB] redirect during wait, latency 3");
        lat_min = 3; lat_max = 3;
        resetDut();
        idleCycle();
        applyStimulus(0, 0, 1, 32'h0000_0103, 0);
        checkOutput("t3_c1_req", imem_req, 0);
        idleCycle();
        checkOutput("t3_c2_req", imem_req, 0);
        idleCycle();
        checkOutput("t3_c3_req", imem_req, 0);
        checkOutput("t3_c3_valid", id_valid, 0);
        idleCycle();
        checkOutput("t3_c4_req", imem_req, 1);
        checkOutput("t3_c4_addr", imem_addr, 32'h0000_0100);
        for (int j = 5; j <= 8; j++) idleCycle();
        checkOutput("t3_c8_valid", id_valid, 1);
        checkOutput("t3_c8_pc", id_pc, 32'h0000_0100);

        $display("[TB] redirect with response and stall");
        lat_min = 1; lat_max = 1;
        resetDut();
        idleCycle();
        idleCycle();
        applyStimulus(0, 1, 1, 32'h0000_0200, 0);
        checkOutput("t4a_req", imem_req, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("t4a_valid", id_valid, 0);
        checkOutput("t4a_addr", imem_addr, 32'h0000_0200);
        idleCycle();
        idleCycle();
        checkOutput("t4a_pc", id_pc, 32'h0000_0200);

        $display("[TB] redirect with full skid");
        resetDut();
        idleCycle();
        idleCycle();
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, 32'h0000_0300, 1);
        checkOutput("t4b_req", imem_req, 0);
        idleCycle();
        checkOutput("t4b_valid", id_valid, 0);
        checkOutput("t4b_req2", imem_req, 1);
        checkOutput("t4b_addr", imem_addr, 32'h0000_0300);
        idleCycle();
        idleCycle();
        checkOutput("t4b_pc", id_pc, 32'h0000_0300);

        $display("[TB] address wrap");
        resetDut();
        applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 0);
        checkOutput("t5_req0", imem_req, 0);
        idleCycle();
        checkOutput("t5_addr1", imem_addr, 32'hFFFF_FFFC);
        idleCycle();
        checkOutput("t5_addr2", imem_addr, 32'h0000_0000);
        idleCycle();
        checkOutput("t5_pc3", id_pc, 32'hFFFF_FFFC);
        idleCycle();
        checkOutput("t5_pc4", id_pc, 32'h0000_0000);

        $display("[TB] reset mid-fetch");
        lat_min = 3; lat_max = 3;
        resetDut();
        for (int j = 0; j < 5; j++) idleCycle();
        checkOutput("t6_pre_valid", id_valid, 1);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("t6_valid", id_valid, 0);
        checkOutput("t6_instr", id_instr, TB_NOP);
        checkOutput("t6_addr", imem_addr, TB_RESET_PC);
        checkOutput("t6_req", imem_req, 1);
        for (int j = 0; j < 4; j++) idleCycle();
        checkOutput("t6_id_valid", id_valid, 1);
        checkOutput("t6_id_pc", id_pc, TB_RESET_PC);

        $display("[TB] randomized traffic");
        lat_min = 1; lat_max = 4;
        resetDut();
        for (int n = 0; n < 3000; n++) begin
            do_rst   = ($urandom_range(199, 0) == 0);
            do_stall = ($urandom_range(9, 0) < 3);
            do_redir = ($urandom_range(24, 0) == 0);
            if ($urandom_range(3, 0) == 0) tgt = 32'hFFFF_FFF0 + ($urandom & 32'hF);
            else tgt = $urandom & 32'h0000_0FFF;
            applyStimulus(do_rst, do_stall, do_redir, tgt, 0);
        end
        r0 = retired;
        for (int n = 0; n < 40; n++) idleCycle();
        checkOutput("drain_progress", (retired - r0) >= 8, 1);
        checkOutput("total_progress", retired > 500, 1);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
